// File: rtl/div_unit_if.sv
// Request/response bundle between the EX stage and the multi-cycle divider.
interface div_unit_if #(
  parameter int DATA_W = 32
);
  logic                  start_i;
  logic                  annul_i;
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;
  logic                  stallreq_o;

  // EX side: issues the request and consumes the result
  modport master (
    output start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    input  result_o, ready_o, stallreq_o
  );

  // Divider side
  modport slave (
    input  start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    output result_o, ready_o, stallreq_o
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU, one quotient bit per cycle.
// Operands are converted to magnitudes on acceptance and the signs are
// re-applied once the unsigned quotient/remainder are complete.
module div_unit #(
  parameter int DATA_W = 32,
  parameter int ITER   = DATA_W
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(ITER + 1);

  localparam logic [1:0] ST_FREE    = 2'b00;
  localparam logic [1:0] ST_DIVZERO = 2'b01;
  localparam logic [1:0] ST_ON      = 2'b10;
  localparam logic [1:0] ST_END     = 2'b11;

  logic [1:0]          state;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   rem_q;
  logic [DATA_W-1:0]   quo_q;
  logic [DATA_W-1:0]   divisor_q;
  logic                neg_quo_q;
  logic                neg_rem_q;
  logic [2*DATA_W-1:0] result_q;
  logic                ready_q;

  logic                neg1;
  logic                neg2;
  logic [DATA_W-1:0]   abs1;
  logic [DATA_W-1:0]   abs2;
  logic [DATA_W+1:0]   trial;
  logic                trial_neg;
  logic [DATA_W-1:0]   quo_fixed;
  logic [DATA_W-1:0]   rem_fixed;

  assign neg1 = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
  assign neg2 = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
  assign abs1 = neg1 ? (~bus.opdata1_i + 1'b1) : bus.opdata1_i;
  assign abs2 = neg2 ? (~bus.opdata2_i + 1'b1) : bus.opdata2_i;

  // The shifted partial remainder always fits in DATA_W+1 bits because the
  // remainder stays below the divisor; one extra bit carries the borrow.
  assign trial     = {1'b0, rem_q, quo_q[DATA_W-1]} - {2'b00, divisor_q};
  assign trial_neg = trial[DATA_W+1];

  assign quo_fixed = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
  assign rem_fixed = neg_rem_q ? (~rem_q + 1'b1) : rem_q;

  assign bus.result_o   = result_q;
  assign bus.ready_o    = ready_q;
  assign bus.stallreq_o = bus.start_i & ~ready_q;

  // Request acceptance, iteration, sign fix-up and result hand-off
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_FREE;
      cnt       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state)
        ST_FREE: begin
          ready_q  <= 1'b0;
          result_q <= '0;
          if (bus.start_i && !bus.annul_i) begin
            if (bus.opdata2_i == '0) begin
              state <= ST_DIVZERO;
            end else begin
              state     <= ST_ON;
              cnt       <= '0;
              rem_q     <= '0;
              quo_q     <= abs1;
              divisor_q <= abs2;
              neg_quo_q <= neg1 ^ neg2;
              neg_rem_q <= neg1;
            end
          end
        end
        ST_DIVZERO: begin
          if (bus.annul_i) begin
            state <= ST_FREE;
          end else begin
            rem_q     <= '0;
            quo_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            state     <= ST_END;
          end
        end
        ST_ON: begin
          if (bus.annul_i) begin
            state <= ST_FREE;
            cnt   <= '0;
          end else begin
            if (trial_neg) begin
              rem_q <= {rem_q[DATA_W-2:0], quo_q[DATA_W-1]};
              quo_q <= {quo_q[DATA_W-2:0], 1'b0};
            end else begin
              rem_q <= trial[DATA_W-1:0];
              quo_q <= {quo_q[DATA_W-2:0], 1'b1};
            end
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(ITER - 1)) begin
              state <= ST_END;
            end
          end
        end
        ST_END: begin
          if (bus.annul_i || !bus.start_i) begin
            state    <= ST_FREE;
            ready_q  <= 1'b0;
            result_q <= '0;
          end else begin
            result_q <= {rem_fixed, quo_fixed};
            ready_q  <= 1'b1;
          end
        end
        default: state <= ST_FREE;
      endcase
    end
  end

endmodule
